// File: rtl/input_pkg.sv
// Shared types, 50 MHz default timing and width helper for the key input front end.
package input_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    REPEAT
  } rpt_state_t;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 250000;
  localparam int unsigned DEF_REPEAT_DELAY    = 25000000;
  localparam int unsigned DEF_REPEAT_PERIOD   = 5000000;

  function automatic int unsigned clog2_max(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/key_channel.sv
// One key: polarity fix, 2-flop synchroniser, debouncer and auto-repeat FSM.
module key_channel
  import input_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  parameter bit          INVERT          = 1'b1,
  parameter bit          REPEAT_EN       = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press,
  output logic release_pulse,
  output logic fire,
  output logic press_nxt
);

  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned RW = clog2_max(REPEAT_DELAY, REPEAT_PERIOD);
  localparam logic [DW-1:0] D_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] DLY_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PER_LAST = RW'((REPEAT_PERIOD == 0) ? 0 : REPEAT_PERIOD - 1);
  localparam bit RPT = REPEAT_EN && (REPEAT_PERIOD != 0);

  logic          s1_q, s1_d, s2_q, s2_d;
  logic          level_q, level_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic          press_q, press_d, release_q, release_d, fire_q, fire_d;
  rpt_state_t    state_q, state_d;
  logic [RW-1:0] rcnt_q, rcnt_d;

  always_comb begin
    s1_d      = raw ^ INVERT;
    s2_d      = s1_q;
    level_d   = level_q;
    dcnt_d    = dcnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    if (s2_q == level_q) begin
      dcnt_d = '0;
    end else if (dcnt_q == D_LAST) begin
      level_d   = s2_q;
      dcnt_d    = '0;
      press_d   = s2_q;
      release_d = ~s2_q;
    end else begin
      dcnt_d = dcnt_q + 1'b1;
    end
  end

  // FSM reacts to the debouncer's next-state pulses so the first fire coincides with press.
  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    fire_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (press_d) begin
          fire_d = 1'b1;
          rcnt_d = '0;
          if (RPT) state_d = DELAY;
        end
      end
      DELAY: begin
        if (release_d) begin
          state_d = IDLE;
          rcnt_d  = '0;
        end else if (rcnt_q == DLY_LAST) begin
          fire_d  = 1'b1;
          rcnt_d  = '0;
          state_d = REPEAT;
        end else begin
          rcnt_d = rcnt_q + 1'b1;
        end
      end
      REPEAT: begin
        if (release_d) begin
          state_d = IDLE;
          rcnt_d  = '0;
        end else if (rcnt_q == PER_LAST) begin
          fire_d = 1'b1;
          rcnt_d = '0;
        end else begin
          rcnt_d = rcnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      level_q   <= 1'b0;
      dcnt_q    <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      fire_q    <= 1'b0;
      state_q   <= IDLE;
      rcnt_q    <= '0;
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      level_q   <= level_d;
      dcnt_q    <= dcnt_d;
      press_q   <= press_d;
      release_q <= release_d;
      fire_q    <= fire_d;
      state_q   <= state_d;
      rcnt_q    <= rcnt_d;
    end
  end

  assign level         = level_q;
  assign press         = press_q;
  assign release_pulse = release_q;
  assign fire          = fire_q;
  assign press_nxt     = press_d;

endmodule

// File: rtl/key_conditioner.sv
// N independent key_channel instances plus a registered OR of their press pulses.
module key_conditioner
  import input_pkg::*;
#(
  parameter int unsigned N               = 4,
  parameter logic [N-1:0] ACTIVE_LOW     = {N{1'b1}},
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  parameter logic [N-1:0] REPEAT_MASK    = {N{1'b1}}
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] raw,
  output logic [N-1:0] level,
  output logic [N-1:0] press,
  // "release" is a reserved word, hence the suffix.
  output logic [N-1:0] release_pulse,
  output logic [N-1:0] fire,
  output logic         any_press
);

  logic [N-1:0] press_nxt;
  logic         any_press_q, any_press_d;

  for (genvar i = 0; i < N; i++) begin : g_ch
    key_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD),
      .INVERT         (ACTIVE_LOW[i]),
      .REPEAT_EN      (REPEAT_MASK[i])
    ) u_ch (
      .clk          (clk),
      .rst          (rst),
      .raw          (raw[i]),
      .level        (level[i]),
      .press        (press[i]),
      .release_pulse(release_pulse[i]),
      .fire         (fire[i]),
      .press_nxt    (press_nxt[i])
    );
  end

  always_comb begin
    any_press_d = |press_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) any_press_q <= 1'b0;
    else     any_press_q <= any_press_d;
  end

  assign any_press = any_press_q;

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner: N=4, debounce 4, repeat delay 10, period 3, channel 3 without repeat.
module tb_key_conditioner;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] raw = 4'hF;
  logic [3:0] level, press, release_pulse, fire;
  logic       any_press;
  logic [16:0] obs;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  always #5 clk = ~clk;

  key_conditioner #(
    .N              (4),
    .ACTIVE_LOW     (4'hF),
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (10),
    .REPEAT_PERIOD  (3),
    .REPEAT_MASK    (4'b0111)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .raw          (raw),
    .level        (level),
    .press        (press),
    .release_pulse(release_pulse),
    .fire         (fire),
    .any_press    (any_press)
  );

  // {level, press, release, fire, any_press}
  assign obs = {level, press, release_pulse, fire, any_press};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [16:0] exp;
    exp = '0;
    rst = 1'b1;
    raw = 4'hF;
    for (int i = 1; i <= 3; i++) begin
      tick();
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL reset_hold i=%0d got=%b exp=%b", i, obs, exp);
      end
    end
    rst = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL reset_idle i=%0d got=%b exp=%b", i, obs, exp);
      end
    end
  endtask

  task automatic test_debounce();
    logic [16:0] exp;
    raw[0] = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      exp = {3'b000, (i >= 6), 3'b000, (i == 6), 4'b0000, 3'b000, (i == 6), (i == 6)};
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL debounce_press i=%0d got=%b exp=%b", i, obs, exp);
      end
    end
    raw[0] = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      exp = {3'b000, (i < 6), 4'b0000, 3'b000, (i == 6), 4'b0000, 1'b0};
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL debounce_release i=%0d got=%b exp=%b", i, obs, exp);
      end
    end
  endtask

  task automatic test_glitch();
    logic [16:0] exp;
    exp = '0;
    raw[1] = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (i == 3) raw[1] = 1'b1;
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL glitch_reject i=%0d got=%b exp=%b", i, obs, exp);
      end
    end
    raw[1] = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (i == 4) raw[1] = 1'b1;
      exp = {2'b00, (i >= 6 && i <= 9), 1'b0,
             2'b00, (i == 6), 1'b0,
             2'b00, (i == 10), 1'b0,
             2'b00, (i == 6), 1'b0,
             (i == 6)};
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL glitch_accept i=%0d got=%b exp=%b", i, obs, exp);
      end
    end
  endtask

  task automatic test_auto_repeat();
    logic [16:0] exp;
    logic        f;
    raw[2] = 1'b0;
    for (int i = 1; i <= 34; i++) begin
      tick();
      if (i == 20) raw[2] = 1'b1;
      f = (i == 6) || (i == 16) || (i == 19) || (i == 22) || (i == 25);
      exp = {1'b0, (i >= 6 && i <= 25), 2'b00,
             1'b0, (i == 6), 2'b00,
             1'b0, (i == 26), 2'b00,
             1'b0, f, 2'b00,
             (i == 6)};
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL auto_repeat i=%0d got=%b exp=%b", i, obs, exp);
      end
    end
  endtask

  task automatic test_repeat_disabled();
    logic [16:0] exp;
    raw[3] = 1'b0;
    for (int i = 1; i <= 34; i++) begin
      tick();
      if (i == 20) raw[3] = 1'b1;
      exp = {(i >= 6 && i <= 25), 3'b000,
             (i == 6), 3'b000,
             (i == 26), 3'b000,
             (i == 6), 3'b000,
             (i == 6)};
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL repeat_disabled i=%0d got=%b exp=%b", i, obs, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [16:0] exp;
    logic [1:0]  p;
    raw[1:0] = 2'b00;
    for (int i = 1; i <= 9; i++) begin
      tick();
      p = (i == 6) ? 2'b11 : 2'b00;
      exp = {2'b00, (i >= 6) ? 2'b11 : 2'b00, 2'b00, p, 4'b0000, 2'b00, p, (i == 6)};
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL simultaneous_press i=%0d got=%b exp=%b", i, obs, exp);
      end
    end
    rst = 1'b1;
    tick();
    exp = '0;
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL mid_reset_clear got=%b exp=%b", obs, exp);
    end
    rst = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      p = (i == 6) ? 2'b11 : 2'b00;
      exp = {2'b00, (i >= 6) ? 2'b11 : 2'b00, 2'b00, p, 4'b0000, 2'b00, p, (i == 6)};
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL post_reset_press i=%0d got=%b exp=%b", i, obs, exp);
      end
    end
    raw[1:0] = 2'b11;
    for (int i = 1; i <= 8; i++) begin
      tick();
      p = (i == 6) ? 2'b11 : 2'b00;
      exp = {2'b00, (i < 6) ? 2'b11 : 2'b00, 4'b0000, 2'b00, p, 4'b0000, 1'b0};
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL simultaneous_release i=%0d got=%b exp=%b", i, obs, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_glitch();
    test_auto_repeat();
    test_repeat_disabled();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/key_conditioner.md
# key_conditioner

Parametrised N-channel push-button front end that replaces the per-key two-flop synchronizer instances between the board keys and game-logic modules such as `location`. Each channel synchronises, debounces and polarity-corrects one raw input. It produces a clean level, single-cycle press/release pulses and an optional auto-repeat "fire" pulse train. All channels are independent and share one clock domain.

## Interface
Parameters:
- `N`, 4, number of channels.
- `ACTIVE_LOW`, `{N{1'b1}}`, per-channel mask; set bit inverts that raw input (DE1 KEYs are active-low).
- `DEBOUNCE_CYCLES`, 250000, consecutive stable cycles required to accept a change (5 ms at 50 MHz); must be ≥1.
- `REPEAT_DELAY`, 25000000, cycles from press to first auto-repeat fire (0.5 s); must be ≥1.
- `REPEAT_PERIOD`, 5000000, cycles between subsequent repeat fires; 0 disables auto-repeat on all channels.
- `REPEAT_MASK`, `{N{1'b1}}`, per-channel auto-repeat enable.

Ports:
- `clk`  in  1  system clock (CLOCK_50).
- `rst`  in  1  synchronous, active-high reset.
- `raw`  in  N  asynchronous raw button/switch inputs.
- `level`  out  N  debounced, polarity-corrected state (1 = pressed).
- `press`  out  N  one-cycle pulse on accepted 0→1 of `level`.
- `release`  out  N  one-cycle pulse on accepted 1→0 of `level`.
- `fire`  out  N  one-cycle pulse on press and on each auto-repeat.
- `any_press`  out  1  OR of `press`.

## Operation
- Per channel, the input passes through polarity XOR, then 2-flop synchroniser `s1`→`s2`.
- Debounce counter `dcnt` has width `$clog2(DEBOUNCE_CYCLES+1)`.
  - If `s2 == level`: `dcnt <= 0`.
  - Else if `dcnt == DEBOUNCE_CYCLES-1`: `level <= s2`, `dcnt <= 0`, and `press` or `release` is pulsed on the same edge.
  - Else: `dcnt <= dcnt+1`.
- Any glitch shorter than `DEBOUNCE_CYCLES` cycles restarts the count and produces no output.
- Repeat FSM per channel, with states IDLE, DELAY, REPEAT. Counter `rcnt` width is `$clog2(max(REPEAT_DELAY,REPEAT_PERIOD)+1)`.
  - IDLE: on press, fire=1, `rcnt<=0`. Go to DELAY if the channel has repeat enabled (`REPEAT_MASK` bit set and `REPEAT_PERIOD`≠0); otherwise stay in IDLE.
  - DELAY: `rcnt` increments. When `rcnt == REPEAT_DELAY-1`: fire=1, `rcnt<=0`, go to REPEAT.
  - REPEAT: `rcnt` increments. When `rcnt == REPEAT_PERIOD-1`: fire=1, `rcnt<=0`.
  - Release in DELAY or REPEAT goes to IDLE immediately. No fire is produced on the release cycle, even if the count matches.
- `fire` is exactly `press` for channels without repeat.
- All outputs are registered. There are no combinational paths from `raw`.

## Timing
- Reset values: `s1`, `s2`, `level`, `press`, `release`, `fire`, `any_press` are 0; counters are 0; FSM is IDLE.
- A key held through reset is treated as newly pressed. Its `press` is reported after normal debounce latency.
- Latency: if `raw` changes before edge k and then stays stable, `level`/`press`/`release` update at edge k+1+`DEBOUNCE_CYCLES`. That is `DEBOUNCE_CYCLES`+2 edges total.
- `press`, `release` and `fire` are high for exactly one cycle. The same channel's `press` and `release` are never both high.
- Minimum spacing between same-channel `press` and `release` is `DEBOUNCE_CYCLES` cycles.
- Fire n≥2 occurs at `REPEAT_DELAY` + (n−2)·`REPEAT_PERIOD` cycles after the press cycle.
- Simultaneous events on different channels are fully independent. Any combination of pulses may coincide.
- Counters saturate by construction (compare-and-clear). There is no wrap-around beyond the terminal value.
- `rst` mid-debounce or mid-repeat discards all state and counts within one cycle.

## Structure
- Shared package `input_pkg`:
  - typedef `rpt_state_t` (IDLE/DELAY/REPEAT).
  - Default-timing localparams for 50 MHz.
  - Function `clog2_max` for counter widths.
- Sub-module `key_channel`: one synchroniser, debouncer and repeat FSM, with scalar ports and the same timing parameters plus per-channel `INVERT` and `REPEAT_EN`.
- `key_conditioner` is a generate loop of N `key_channel` instances plus the registered `any_press` OR.

## Test plan
Benches use `N`=4, `DEBOUNCE_CYCLES`=4, `REPEAT_DELAY`=10, `REPEAT_PERIOD`=3 unless noted. Pulse counts below are for one 20-cycle hold.

- **Reset:** hold `rst` 3 cycles with `raw`=4'hF (all released, active-low).
  - Required: all outputs 0 throughout.
  - Required: no pulses during the next 20 cycles.
- **Debounce accept:** `raw[0]` 1→0 before edge k, then held.
  - Required: `press[0]`, `fire[0]` and `any_press` high only at edge k+5.
  - Required: `level[0]`=1 from edge k+5.
- **Glitch reject:** `raw[1]` low for 3 cycles, then high.
  - Required: `level[1]` stays 0 and no pulses occur.
  - Then low for 4 cycles: `press[1]` fires once.
- **Auto-repeat:** channel 2 pressed at cycle P and held 20 cycles.
  - Required: `fire[2]` at P, P+10, P+13, P+16, P+19.
  - On release: `release[2]` once, no further fire.
- **Repeat disabled:** `REPEAT_MASK`=4'b0111, channel 3 held 20 cycles.
  - Required: exactly one `fire[3]`, coincident with `press[3]`.
- **Simultaneous and mid-operation reset:** channels 0 and 1 pressed on the same edge.
  - Required: both `press` bits pulse together.
  - `rst` asserted during repeat DELAY with raw still held: outputs clear next edge.
  - Required: a new `press` at rst-deassert + 5 cycles.
